// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide engine: shift-add multiply, restoring divide,
// one bit per cycle, with a single-cycle path for RISC-V divide special cases.
module muldiv_unit #(
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [W-1:0] MOST_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(W - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state;
  logic [2:0]           op;
  logic [CNT_WIDTH-1:0] cnt;
  logic [W-1:0]         mcand;
  logic [2*W-1:0]       acc;
  logic [W:0]           rem;
  logic [W-1:0]         quot;
  logic                 neg_res;
  logic                 neg_rem;

  logic           is_div, a_signed, b_signed, a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;
  logic           div_zero, div_ovf, fast;
  logic [W-1:0]   fast_res;

  always_comb begin
    is_div   = funct3[2];
    a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
    a_neg    = a_signed & op_a[W-1];
    b_neg    = b_signed & op_b[W-1];
    a_mag    = a_neg ? (~op_a + 1'b1) : op_a;
    b_mag    = b_neg ? (~op_b + 1'b1) : op_b;
    div_zero = (op_b == '0);
    div_ovf  = ~funct3[0] && (op_a == MOST_NEG) && (op_b == '1);
    fast     = is_div & (div_zero | div_ovf);
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (div_zero) fast_res = funct3[1] ? op_a : '1;
    else          fast_res = funct3[1] ? '0 : op_a;
  end

  logic [W:0]     mul_sum;
  logic [2*W-1:0] acc_step;
  logic [W:0]     rem_shift, rem_diff, rem_step;
  logic [W-1:0]   quot_step;
  logic [2*W-1:0] prod;
  logic [W-1:0]   quot_f, rem_f, calc_res;

  always_comb begin
    mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, mcand};
    acc_step  = acc[0] ? {mul_sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
    rem_shift = {rem[W-1:0], quot[W-1]};
    rem_diff  = rem_shift - {1'b0, mcand};
    rem_step  = rem_diff[W] ? rem_shift : rem_diff;
    quot_step = {quot[W-2:0], ~rem_diff[W]};
    // Sign fix-up is applied to the final-iteration values so result lands on the DONE edge
    prod      = neg_res ? (~acc_step + 1'b1) : acc_step;
    quot_f    = neg_res ? (~quot_step + 1'b1) : quot_step;
    rem_f     = neg_rem ? (~rem_step[W-1:0] + 1'b1) : rem_step[W-1:0];
    if (op[2])               calc_res = op[1] ? rem_f : quot_f;
    else if (op[1:0] == 2'b00) calc_res = prod[W-1:0];
    else                     calc_res = prod[2*W-1:W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      op      <= '0;
      cnt     <= '0;
      mcand   <= '0;
      acc     <= '0;
      rem     <= '0;
      quot    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !flush) begin
            op      <= funct3;
            cnt     <= '0;
            mcand   <= is_div ? b_mag : a_mag;
            acc     <= {{W{1'b0}}, b_mag};
            rem     <= '0;
            quot    <= a_mag;
            neg_res <= a_neg ^ b_neg;
            neg_rem <= a_neg;
            if (fast) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= fast_res;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            acc  <= acc_step;
            rem  <= rem_step;
            quot <= quot_step;
            if (cnt == LAST_ITER) begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              result <= calc_res;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at the default 32-bit width.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int errs  = 0;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge of the cycle after the sampling edge,
  // with operands scrambled so only latched values can produce the right answer.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0; funct3 = f ^ 3'b101; op_a = ~a; op_b = b ^ 32'h0000_0005;
  endtask

  task automatic wait_done(output int lat, output int busy_n);
    lat = 0; busy_n = 0;
    for (int i = 1; i <= 100; i++) begin
      if (done === 1'b1) begin
        lat = i;
        break;
      end
      if (busy === 1'b1) busy_n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    #1;
    total++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", done); end
    total++; if (result !== 32'h0) begin errs++; $display("FAIL reset_result: got %h expected 00000000", result); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    int lat, bn;
    issue(F_MUL, 32'd7, 32'hFFFF_FFFD);
    wait_done(lat, bn);
    total++; if (result !== 32'hFFFF_FFEB) begin errs++; $display("FAIL mul_result: got %h expected ffffffeb", result); end
    total++; if (bn !== 32) begin errs++; $display("FAIL mul_busy_cycles: got %0d expected 32", bn); end
    total++; if (lat !== 33) begin errs++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    total++; if (busy !== 1'b0) begin errs++; $display("FAIL mul_busy_with_done: got %b expected 0", busy); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin errs++; $display("FAIL mul_done_pulse: got %b expected 0", done); end
    total++; if (result !== 32'hFFFF_FFEB) begin errs++; $display("FAIL mul_result_hold: got %h expected ffffffeb", result); end
  endtask

  task automatic test_mul_high();
    int lat, bn;
    issue(F_MULH, 32'h8000_0000, 32'h8000_0000);
    wait_done(lat, bn);
    total++; if (result !== 32'h4000_0000) begin errs++; $display("FAIL mulh: got %h expected 40000000", result); end
    @(negedge clk);
    issue(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(lat, bn);
    total++; if (result !== 32'hFFFF_FFFE) begin errs++; $display("FAIL mulhu: got %h expected fffffffe", result); end
    @(negedge clk);
    issue(F_MULHSU, 32'hFFFF_FFFF, 32'd2);
    wait_done(lat, bn);
    total++; if (result !== 32'hFFFF_FFFF) begin errs++; $display("FAIL mulhsu: got %h expected ffffffff", result); end
    total++; if (lat !== 33) begin errs++; $display("FAIL mulhsu_latency: got %0d expected 33", lat); end
    @(negedge clk);
  endtask

  task automatic test_div();
    int lat, bn;
    issue(F_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bn);
    total++; if (result !== 32'hFFFF_FFFD) begin errs++; $display("FAIL div_neg: got %h expected fffffffd", result); end
    @(negedge clk);
    issue(F_REM, 32'hFFFF_FFF9, 32'd2);
    wait_done(lat, bn);
    total++; if (result !== 32'hFFFF_FFFF) begin errs++; $display("FAIL rem_neg: got %h expected ffffffff", result); end
    @(negedge clk);
    issue(F_DIVU, 32'd100, 32'd7);
    wait_done(lat, bn);
    total++; if (result !== 32'd14) begin errs++; $display("FAIL divu: got %h expected 0000000e", result); end
    total++; if (lat !== 33) begin errs++; $display("FAIL divu_latency: got %0d expected 33", lat); end
    @(negedge clk);
    issue(F_REMU, 32'd100, 32'd7);
    wait_done(lat, bn);
    total++; if (result !== 32'd2) begin errs++; $display("FAIL remu: got %h expected 00000002", result); end
    @(negedge clk);
  endtask

  task automatic test_fast_path();
    int lat, bn;
    issue(F_DIV, 32'd5, 32'd0);
    wait_done(lat, bn);
    total++; if (result !== 32'hFFFF_FFFF) begin errs++; $display("FAIL div_by_zero: got %h expected ffffffff", result); end
    total++; if (lat !== 1) begin errs++; $display("FAIL div_by_zero_latency: got %0d expected 1", lat); end
    @(negedge clk);
    issue(F_REM, 32'd5, 32'd0);
    wait_done(lat, bn);
    total++; if (result !== 32'd5) begin errs++; $display("FAIL rem_by_zero: got %h expected 00000005", result); end
    total++; if (busy !== 1'b0) begin errs++; $display("FAIL rem_by_zero_busy: got %b expected 0", busy); end
    @(negedge clk);
    issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bn);
    total++; if (result !== 32'h8000_0000) begin errs++; $display("FAIL div_overflow: got %h expected 80000000", result); end
    total++; if (bn !== 0) begin errs++; $display("FAIL div_overflow_busy: got %0d expected 0", bn); end
    @(negedge clk);
    issue(F_REM, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(lat, bn);
    total++; if (result !== 32'h0) begin errs++; $display("FAIL rem_overflow: got %h expected 00000000", result); end
    total++; if (lat !== 1) begin errs++; $display("FAIL rem_overflow_latency: got %0d expected 1", lat); end
    @(negedge clk);
  endtask

  task automatic test_flush();
    int lat, bn;
    int seen;
    issue(F_MUL, 32'd7, 32'hFFFF_FFFD);
    wait_done(lat, bn);
    @(negedge clk);
    issue(F_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin errs++; $display("FAIL flush_busy: got %b expected 0", busy); end
    total++; if (result !== 32'hFFFF_FFEB) begin errs++; $display("FAIL flush_result_kept: got %h expected ffffffeb", result); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      @(negedge clk);
    end
    total++; if (seen !== 0) begin errs++; $display("FAIL flush_no_done: got %0d expected 0", seen); end
    start = 1'b1; flush = 1'b1; funct3 = F_DIVU; op_a = 32'd1000; op_b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    total++; if ({busy, done} !== 2'b00) begin errs++; $display("FAIL start_flush_dropped: got %b expected 00", {busy, done}); end
    issue(F_DIVU, 32'd1000, 32'd3);
    wait_done(lat, bn);
    total++; if (result !== 32'd333) begin errs++; $display("FAIL after_flush_divu: got %h expected 0000014d", result); end
    total++; if (lat !== 33) begin errs++; $display("FAIL after_flush_latency: got %0d expected 33", lat); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_calc();
    issue(F_MUL, 32'd6, 32'd7);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin errs++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
    total++; if (done !== 1'b0) begin errs++; $display("FAIL async_rst_done: got %b expected 0", done); end
    total++; if (result !== 32'h0) begin errs++; $display("FAIL async_rst_result: got %h expected 00000000", result); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    issue(F_MUL, 32'd6, 32'd7);
    wait_done(lat, bn);
    total++; if (result !== 32'd42) begin errs++; $display("FAIL b2b_first: got %h expected 0000002a", result); end
    issue(F_DIVU, 32'd100, 32'd7);
    total++; if (busy !== 1'b1) begin errs++; $display("FAIL b2b_busy_next: got %b expected 1", busy); end
    wait_done(lat, bn);
    total++; if (result !== 32'd14) begin errs++; $display("FAIL b2b_second: got %h expected 0000000e", result); end
    total++; if (bn !== 32) begin errs++; $display("FAIL b2b_busy_cycles: got %0d expected 32", bn); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_fast_path();
    test_flush();
    test_reset_mid_calc();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, errs);
    $finish;
  end

endmodule
